// File: rtl/hazard_forwarding_unit.sv
// Purpose : MIPS 5-stage hazard controller; ID operand forwarding selects, load-use and HI/LO stalls, MULT/DIV busy tracking.
// Latency : selects, load-enables and NOP are combinational from current inputs and md_cnt; no added latency.
// Backpres: on stall it holds PC and IF/ID (LE=0) and injects a bubble into ID/EX (NOP=1) for as long as the hazard remains.
// Optional: define HAZARD_STALL_COUNT_EN to build the saturating stall-cycle counter; otherwise STALL_COUNT is tied to 0.

module hazard_forwarding_unit #(
  parameter int MULDIV_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_USES_RS,
  input  logic        ID_USES_RT,
  input  logic        ID_READS_HILO,
  input  logic        ID_MULDIV_ISSUE,
  input  logic [4:0]  EX_REG,
  input  logic        EX_RF_ENABLE,
  input  logic        EX_LOAD_INSTR,
  input  logic [4:0]  MEM_REG,
  input  logic        MEM_RF_ENABLE,
  input  logic [4:0]  WB_REG,
  input  logic        WB_RF_ENABLE,
  output logic [1:0]  MX1_SEL,
  output logic [1:0]  MX2_SEL,
  output logic        PC_LE,
  output logic        IF_ID_LE,
  output logic        ID_EX_NOP,
  output logic        MD_BUSY,
  output logic [31:0] STALL_COUNT
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  localparam logic [3:0] MD_LAT = 4'(MULDIV_LATENCY);

  typedef enum logic {
    RUN,
    MD_WAIT
  } md_state_e;

  md_state_e  state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic [2:0] rs_fwd, rt_fwd;
  logic       load_use;
  logic       md_pending;
  logic       hilo_stall;
  logic       stall;

  // Per-source resolution. Result is {load_hit, sel[1:0]}. A load in EX
  // whose destination matches cannot be bypassed (data not ready yet), so
  // it reports a hit and leaves the select at RF; MEM/WB are deliberately
  // not consulted because the older value there would be stale.
  function automatic logic [2:0] resolve_src(
    input logic [4:0] src,
    input logic       used,
    input logic [4:0] ex_reg,
    input logic       ex_en,
    input logic       ex_ld,
    input logic [4:0] mem_reg,
    input logic       mem_en,
    input logic [4:0] wb_reg,
    input logic       wb_en
  );
    logic [2:0] r;
    r = {1'b0, SEL_RF};
    if (used && (src != 5'd0)) begin
      if (ex_en && (src == ex_reg)) begin
        if (ex_ld) begin
          r = {1'b1, SEL_RF};
        end else begin
          r = {1'b0, SEL_EX};
        end
      end else if (mem_en && (src == mem_reg)) begin
        r = {1'b0, SEL_MEM};
      end else if (wb_en && (src == wb_reg)) begin
        r = {1'b0, SEL_WB};
      end
    end
    return r;
  endfunction

  // Forwarding lookups for rs (MX1) and rt (MX2).
  always_comb begin
    rs_fwd = resolve_src(ID_RS, ID_USES_RS, EX_REG, EX_RF_ENABLE, EX_LOAD_INSTR,
                         MEM_REG, MEM_RF_ENABLE, WB_REG, WB_RF_ENABLE);
    rt_fwd = resolve_src(ID_RT, ID_USES_RT, EX_REG, EX_RF_ENABLE, EX_LOAD_INSTR,
                         MEM_REG, MEM_RF_ENABLE, WB_REG, WB_RF_ENABLE);
  end

  // Stall decision; both hazard types collapse into a single stall cycle.
  // Reset suppresses the stall so the pipeline flows while being cleared.
  always_comb begin
    load_use   = rs_fwd[2] | rt_fwd[2];
    md_pending = (md_cnt_q != 4'd0);
    hilo_stall = md_pending & (ID_READS_HILO | ID_MULDIV_ISSUE);
    stall      = ~Reset & (load_use | hilo_stall);
  end

  // Upstream control outputs, forced to their benign values during reset.
  always_comb begin
    MX1_SEL   = Reset ? SEL_RF : rs_fwd[1:0];
    MX2_SEL   = Reset ? SEL_RF : rt_fwd[1:0];
    PC_LE     = ~stall;
    IF_ID_LE  = ~stall;
    ID_EX_NOP = stall;
    MD_BUSY   = ~Reset & md_pending;
  end

  // MULT/DIV tracker next state: load latency on an accepted issue, otherwise
  // count down; a stalled issue is dropped and the countdown continues.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (ID_MULDIV_ISSUE && !stall) begin
          md_cnt_d = MD_LAT;
          state_d  = MD_WAIT;
        end
      end
      MD_WAIT: begin
        if (ID_MULDIV_ISSUE && !stall) begin
          md_cnt_d = MD_LAT;
        end else if (md_cnt_q != 4'd0) begin
          md_cnt_d = md_cnt_q - 4'd1;
          if (md_cnt_q == 4'd1) begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 4'd0;
      end
    endcase
  end

  // MULT/DIV tracker state register; reset drops straight back to RUN.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall performance counter next value, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall performance counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_COUNT = stall_cnt_q;
`else
  assign STALL_COUNT = 32'd0;
`endif

endmodule

// File: doc/hazard_forwarding_unit.md
# hazard_forwarding_unit

Pipeline hazard controller for the five-stage MIPS core. It reads the destination/enable fields that the ID/EX, EX/MEM and MEM/WB pipeline registers publish and drives control back upstream: operand-forwarding selects for the ID-stage MX1/MX2 muxes, load-enables for the PC and IF/ID register, and a NOP-insert request into ID/EX. It also owns a multi-cycle HI/LO busy tracker that stalls HI/LO consumers until a MULT/DIV result is valid.

## Interface
Parameters:
- MULDIV_LATENCY, 4: cycles from MULT/DIV leaving ID until HI/LO is readable (1..15).

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ID_RS / ID_RT  in  5 each  source register fields of the instruction in ID.
- ID_USES_RS / ID_USES_RT  in  1 each  the ID instruction actually reads that source.
- ID_READS_HILO  in  1  ID instruction is MFHI/MFLO.
- ID_MULDIV_ISSUE  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- EX_REG  in  5  destination register in EX (ID/EX OUT_regEX).
- EX_RF_ENABLE, EX_LOAD_INSTR  in  1 each  EX writes RF / EX is a load.
- MEM_REG, MEM_RF_ENABLE  in  5, 1  destination and write-enable in MEM.
- WB_REG, WB_RF_ENABLE  in  5, 1  destination and write-enable in WB.
- MX1_SEL / MX2_SEL  out  2 each  operand source for rs / rt: 00 RF, 01 EX result, 10 MEM result, 11 WB PW.
- PC_LE  out  1  PC load-enable (0 = hold).
- IF_ID_LE  out  1  IF/ID load-enable (0 = hold).
- ID_EX_NOP  out  1  force all ID/EX control signals to 0 this cycle.
- MD_BUSY  out  1  HI/LO result pending.
- STALL_COUNT  out  32  stall-cycle performance counter.

## Operation
- Forwarding (per source, rs→MX1, rt→MX2): if source field is 0 or not used → 00. Else priority EX > MEM > WB: EX match with EX_RF_ENABLE and not EX_LOAD_INSTR → 01; MEM match with MEM_RF_ENABLE → 10; WB match with WB_RF_ENABLE → 11; else 00. A matching load in EX never forwards from EX; it raises a load stall and lower stages are ignored for that source.
- Load-use stall: EX_LOAD_INSTR & EX_RF_ENABLE & EX_REG≠0 & EX_REG matches a used ID source.
- HI/LO stall: MD_BUSY & (ID_READS_HILO | ID_MULDIV_ISSUE).
- stall = load-use | HI/LO. When stall: PC_LE=0, IF_ID_LE=0, ID_EX_NOP=1. Else PC_LE=1, IF_ID_LE=1, ID_EX_NOP=0. Forwarding selects are computed regardless of stall.
- MD tracker, 4-bit counter md_cnt; states RUN (md_cnt=0) and MD_WAIT (md_cnt≠0); MD_BUSY = (md_cnt≠0).
  - ID_MULDIV_ISSUE & !stall: md_cnt ← MULDIV_LATENCY (RUN→MD_WAIT).
  - else if md_cnt≠0: md_cnt ← md_cnt−1; MD_WAIT→RUN when it reaches 0.
  - Issue while stalled is not accepted; the counter keeps decrementing.

## Timing
- Selects, LEs and NOP are combinational from current inputs and md_cnt; no added latency.
- Load-use stall lasts exactly one cycle (the load moves to MEM, then MEM forwarding, sel 10).
- MULT issued at cycle t (not stalled): MD_BUSY=1 for cycles t+1..t+MULDIV_LATENCY; a dependent MFHI is released in cycle t+MULDIV_LATENCY+1.
- Reset high at an edge: md_cnt←0, STALL_COUNT←0. While Reset is high, outputs are forced to MX1_SEL=MX2_SEL=00, PC_LE=1, IF_ID_LE=1, ID_EX_NOP=0, MD_BUSY=0. Reset mid-MD_WAIT drops straight to RUN.
- Load stall and HI/LO stall in the same cycle: one stall cycle, counted once.

## Configuration
- HAZARD_STALL_COUNT_EN defined: STALL_COUNT increments by 1 on every edge where stall=1 and Reset=0. It saturates at 32'hFFFF_FFFF.
- Not defined: no counter register; STALL_COUNT is tied to 0.

## Test plan
- EX_REG=5, EX_RF_ENABLE=1, not load; ID_RS=5, used → MX1_SEL=01, PC_LE=1, no NOP.
- EX and MEM both write reg 7; ID_RT=7 → MX2_SEL=01. Same case with ID_RT=0 → 00.
- Load in EX to reg 3; ID_RS=3 → one cycle with PC_LE=IF_ID_LE=0, ID_EX_NOP=1. Next cycle, with the load in MEM → MX1_SEL=10, no stall. STALL_COUNT=1 (macro on).
- MULT issue with MULDIV_LATENCY=4, then MFHI held in ID → stalled 4 cycles, released on the 5th; MD_BUSY high for exactly 4 cycles.
- Reset asserted during MD_WAIT (md_cnt=2) → next cycle MD_BUSY=0, STALL_COUNT=0, and MFHI is not stalled.
- WB_REG=9 with WB_RF_ENABLE=0, ID_RS=9 → MX1_SEL=00. With WB_RF_ENABLE=1 → 11.
